// File: rtl/adder_tree_seq_if.sv
// Control/status bundle between the window generator, adder_tree_seq and the result writer.
// Carries bubble_cnt only when ADDER_TREE_SEQ_PERF_EN is defined.
interface adder_tree_seq_if #(
    parameter int unsigned NUM_STAGES = 4,
    parameter int unsigned CNT_W      = 16
);
    logic                  start;
    logic [CNT_W-1:0]      num_windows;
    logic                  in_valid;
    logic                  in_ready;
    logic [NUM_STAGES-1:0] stage_en;
    logic                  out_valid;
    logic                  busy;
    logic                  done;
    logic [CNT_W-1:0]      out_count;
`ifdef ADDER_TREE_SEQ_PERF_EN
    logic [CNT_W-1:0]      bubble_cnt;
`endif

    modport master (
`ifdef ADDER_TREE_SEQ_PERF_EN
        input  bubble_cnt,
`endif
        output start, num_windows, in_valid,
        input  in_ready, stage_en, out_valid, busy, done, out_count
    );

    modport slave (
`ifdef ADDER_TREE_SEQ_PERF_EN
        output bubble_cnt,
`endif
        input  start, num_windows, in_valid,
        output in_ready, stage_en, out_valid, busy, done, out_count
    );
endinterface

// File: rtl/adder_tree_seq.sv
// Sequencer for the pipelined adder tree: per-stage enables, output valid, drain and done.
// Optional bubble counter enabled by defining ADDER_TREE_SEQ_PERF_EN.
module adder_tree_seq #(
    parameter int unsigned NUM_STAGES = 4,
    parameter int unsigned CNT_W      = 16
) (
    input logic              clk,
    input logic              rst_n,
    adder_tree_seq_if.slave  bus_io
);
    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      num_q, num_d;
    logic [CNT_W-1:0]      in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]      out_cnt_q, out_cnt_d;
    logic [NUM_STAGES-1:0] vsr_q, vsr_d;
    logic                  accept;

    assign accept = (state_q == StRun) && bus_io.in_valid;
    assign vsr_d  = {vsr_q[NUM_STAGES-2:0], accept};

    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        if (vsr_q[NUM_STAGES-1] && (out_cnt_q != '1)) begin
            out_cnt_d = out_cnt_q + CNT_W'(1);
        end
        case (state_q)
            StIdle: begin
                if (bus_io.start) begin
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    if (bus_io.num_windows != '0) begin
                        num_d   = bus_io.num_windows;
                        state_d = StRun;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StRun: begin
                if (accept) begin
                    in_cnt_d = in_cnt_q + CNT_W'(1);
                    if (in_cnt_d == num_q) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // Leave once nothing is left behind the final stage, so done lands right
                // after the last out_valid.
                if (vsr_q[NUM_STAGES-2:0] == '0) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            num_q     <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            vsr_q     <= '0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            vsr_q     <= vsr_d;
        end
    end

    assign bus_io.in_ready  = (state_q == StRun);
    assign bus_io.stage_en  = {vsr_q[NUM_STAGES-2:0], accept};
    assign bus_io.out_valid = vsr_q[NUM_STAGES-1];
    assign bus_io.busy      = (state_q == StRun) || (state_q == StDrain);
    assign bus_io.done      = (state_q == StDone);
    assign bus_io.out_count = out_cnt_q;

`ifdef ADDER_TREE_SEQ_PERF_EN
    logic [CNT_W-1:0] bubble_q, bubble_d;

    always_comb begin
        bubble_d = bubble_q;
        if ((state_q == StRun) && !bus_io.in_valid && (bubble_q != '1)) begin
            bubble_d = bubble_q + CNT_W'(1);
        end
        if ((state_q == StIdle) && bus_io.start) begin
            bubble_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_q <= '0;
        end else begin
            bubble_q <= bubble_d;
        end
    end

    assign bus_io.bubble_cnt = bubble_q;
`endif
endmodule

// File: tb/tb_adder_tree_seq.sv
// Directed bench for adder_tree_seq: reset, streaming, bubbles, back-to-back, zero-window jobs.
// Checks bubble_cnt as well when ADDER_TREE_SEQ_PERF_EN is defined.
module tb_adder_tree_seq;
    localparam int unsigned NS = 4;
    localparam int unsigned CW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    adder_tree_seq_if #(.NUM_STAGES(NS), .CNT_W(CW)) bus_if ();

    adder_tree_seq #(.NUM_STAGES(NS), .CNT_W(CW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One bit per cycle; cycle 0 is the cycle start is driven. Entered at posedge+1.
    task automatic run_job(input string name, input logic [CW-1:0] num, input int ncyc,
                           input logic [15:0] strt, input logic [15:0] vin,
                           input logic [15:0] e_rdy, input logic [15:0] e_en0,
                           input logic [15:0] e_en3, input logic [15:0] e_ov,
                           input logic [15:0] e_busy, input logic [15:0] e_done);
        for (int c = 0; c < ncyc; c++) begin
            bus_if.start       = strt[c];
            bus_if.num_windows = num;
            bus_if.in_valid    = vin[c];
            #1;
            check($sformatf("%s rdy c%0d", name, c), 32'(bus_if.in_ready), 32'(e_rdy[c]));
            check($sformatf("%s en0 c%0d", name, c), 32'(bus_if.stage_en[0]), 32'(e_en0[c]));
            check($sformatf("%s en3 c%0d", name, c), 32'(bus_if.stage_en[3]), 32'(e_en3[c]));
            check($sformatf("%s ov c%0d", name, c), 32'(bus_if.out_valid), 32'(e_ov[c]));
            check($sformatf("%s busy c%0d", name, c), 32'(bus_if.busy), 32'(e_busy[c]));
            check($sformatf("%s done c%0d", name, c), 32'(bus_if.done), 32'(e_done[c]));
            if (c == 1) begin
                check($sformatf("%s cnt_clr", name), 32'(bus_if.out_count), 32'd0);
            end
            @(posedge clk);
            #1;
        end
        bus_if.start    = 1'b0;
        bus_if.in_valid = 1'b0;
    endtask

    initial begin
        bus_if.start       = 1'b0;
        bus_if.num_windows = '0;
        bus_if.in_valid    = 1'b0;

        #3;
        check("rst in_ready", 32'(bus_if.in_ready), 32'd0);
        check("rst stage_en", 32'(bus_if.stage_en), 32'd0);
        check("rst out_valid", 32'(bus_if.out_valid), 32'd0);
        check("rst busy", 32'(bus_if.busy), 32'd0);
        check("rst done", 32'(bus_if.done), 32'd0);
        check("rst out_count", 32'(bus_if.out_count), 32'd0);
`ifdef ADDER_TREE_SEQ_PERF_EN
        check("rst bubble_cnt", 32'(bus_if.bubble_cnt), 32'd0);
`endif
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Streaming, 8 windows; stray start in RUN (c3) and DRAIN (c10), in_valid held in DRAIN.
        run_job("stream", 16'd8, 16, 16'h0409, 16'h1FFE,
                16'h01FE, 16'h01FE, 16'h0FF0, 16'h1FE0, 16'h1FFE, 16'h2000);
        check("stream out_count", 32'(bus_if.out_count), 32'd8);

        // Bubbles: in_valid 1,0,1,1,0,0,1,1 from c1, 5 windows.
        run_job("bubble", 16'd5, 14, 16'h0001, 16'h019A,
                16'h01FE, 16'h019A, 16'h0CD0, 16'h19A0, 16'h1FFE, 16'h2000);
        check("bubble out_count", 32'(bus_if.out_count), 32'd5);
`ifdef ADDER_TREE_SEQ_PERF_EN
        check("bubble bubble_cnt", 32'(bus_if.bubble_cnt), 32'd3);
`endif

        // Back-to-back: starts in the IDLE cycle right after the previous done.
        run_job("b2b", 16'd3, 10, 16'h0001, 16'h000E,
                16'h000E, 16'h000E, 16'h0070, 16'h00E0, 16'h00FE, 16'h0100);
        check("b2b out_count", 32'(bus_if.out_count), 32'd3);

        // Zero-window job with in_valid held high throughout.
        run_job("zero", 16'd0, 4, 16'h0001, 16'h000F,
                16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0002);
        check("zero out_count", 32'(bus_if.out_count), 32'd0);

        // Mid-job asynchronous reset.
        bus_if.start       = 1'b1;
        bus_if.num_windows = 16'd4;
        @(posedge clk);
        #1;
        bus_if.start    = 1'b0;
        bus_if.in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("abort pre busy", 32'(bus_if.busy), 32'd1);
        check("abort pre stage_en", 32'(bus_if.stage_en), 32'h3);
        rst_n = 1'b0;
        #1;
        check("abort stage_en", 32'(bus_if.stage_en), 32'd0);
        check("abort busy", 32'(bus_if.busy), 32'd0);
        check("abort in_ready", 32'(bus_if.in_ready), 32'd0);
        bus_if.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("abort hold stage_en", 32'(bus_if.stage_en), 32'd0);
        check("abort out_count", 32'(bus_if.out_count), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/adder_tree_seq.md
# adder_tree_seq

Sequencer for the pipelined adder tree in the convolution stage-2 datapath. It latches a window count, accepts one product set per cycle from the multiplier stage, and drives a per-stage `enable` so that each adder stage is enabled exactly when its inputs hold valid data. Each adder stage registers its sum when enabled and zeroes its output otherwise. The block also flags the tree output as valid, drains the pipeline, and signals completion. It sits between the convolution window generator and the result writer.

## Interface
- `NUM_STAGES`, default 4: number of register stages in the adder tree (≥2).
- `CNT_W`, default 16: width of window counters.
- `clk` input 1: sole clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: single-cycle request to begin a job; sampled only in IDLE.
- `num_windows` input CNT_W: windows in the job; latched on accepted `start`.
- `in_valid` input 1: product set for one window present at the stage-1 inputs.
- `in_ready` output 1: block accepts a product set this cycle.
- `stage_en` output NUM_STAGES: `enable` for adder stage k (bit 0 = first stage).
- `out_valid` output 1: final-stage adder output holds a valid window sum.
- `busy` output 1: job in progress (RUN or DRAIN).
- `done` output 1: one-cycle pulse at job completion.
- `out_count` output CNT_W: window sums emitted in the current or last job.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On `start` with `num_windows`≠0: latch `num_windows`, clear `in_cnt` and `out_count`, go to RUN.
  - On `start` with `num_windows`=0: go directly to DONE.
- RUN:
  - `in_ready`=1.
  - Accept = `in_valid` & `in_ready`; each accept increments `in_cnt`.
  - The accept that brings `in_cnt` to the latched count moves the FSM to DRAIN.
- DRAIN:
  - `in_ready`=0.
  - When the valid shift register is all zero and no `out_valid` is pending, go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Valid tracking: shift register `vsr[NUM_STAGES-1:0]`.
  - `vsr[0]` ← accept.
  - `vsr[k]` ← `vsr[k-1]`.
- Enable generation:
  - `stage_en[0]` = accept (combinational).
  - `stage_en[k]` = `vsr[k-1]` for k≥1.
- `out_valid` = `vsr[NUM_STAGES-1]`; each assertion increments `out_count`.
- Boundaries:
  - `start` outside IDLE is ignored.
  - `in_valid` outside RUN is ignored and has no effect on `stage_en`.
  - Bubbles (`in_valid`=0 in RUN) propagate as zero enables, so downstream stages output 0 and `out_valid` stays low.
  - `out_count` saturates at all-ones.

## Timing
- Reset values: state IDLE, `vsr`=0, `in_ready`=0, `stage_en`=0, `out_valid`=0, `busy`=0, `done`=0, `out_count`=0.
- Reset asserted mid-job aborts immediately. There is no drain; adder stages see `enable`=0 from the next edge.
- Latency: a window accepted in cycle t gives `out_valid`=1 in cycle t+NUM_STAGES.
- Throughput: one window per cycle.
- `start` in cycle t gives `busy`=1 and `in_ready`=1 in cycle t+1.
- The last accept in cycle t gives:
  - `busy`=0 and `done`=1 in cycle t+NUM_STAGES+1.
  - IDLE in cycle t+NUM_STAGES+2.
- Zero-window job: `start` in cycle t gives `done`=1 in cycle t+1 with `out_count`=0.
- `start` is accepted again in the IDLE cycle immediately after DONE.

## Configuration
- `ADDER_TREE_SEQ_PERF_EN`:
  - Defined: adds output `bubble_cnt` [CNT_W-1:0]. It counts RUN cycles with `in_valid`=0, clears on accepted `start`, saturates at all-ones, and resets to 0.
  - Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset: with `rst_n`=0 from time 0, all outputs are 0. Asserting `rst_n`=0 during RUN clears `stage_en` and `busy` asynchronously, without waiting for a clock edge.
- Streaming job: NUM_STAGES=4, `num_windows`=8, `in_valid` held high. Expect:
  - 8 consecutive `out_valid` pulses, the first 4 cycles after the first accept.
  - `out_count`=8.
  - `done` pulses exactly once, 5 cycles after the 8th accept.
- Bubbles: `num_windows`=5, `in_valid` pattern 1,0,1,1,0,0,1,1. Expect:
  - `stage_en[3]` reproduces the accept pattern delayed by 3 cycles.
  - `out_valid` reproduces it delayed by 4 cycles.
  - `out_count`=5.
  - With `ADDER_TREE_SEQ_PERF_EN` defined, `bubble_cnt`=3.
- Zero-window job: `start` with `num_windows`=0 gives `done` the next cycle, with `busy` never asserted and `stage_en` staying 0.
- Ignored requests: `start` pulsed during RUN and DRAIN has no effect. `in_valid`=1 during DRAIN gives `in_ready`=0 and `stage_en[0]`=0.
- Back-to-back jobs: a second `start` in the cycle after `done` (`num_windows`=3) completes correctly, and `out_count` restarts from 0 to reach 3.
